// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, address defaults and the
// R/W bit position within the address byte.
package i2c_pkg;

  localparam logic [6:0] DEF_ADDR     = 7'h50;
  localparam int         DEF_FILT_LEN = 3;
  localparam int         RW_BIT       = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_WAIT     = 3'd7
  } state_e;

  function automatic logic addr_hit(input logic [7:0] addr_byte, input logic [6:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_pin_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one open-drain bus
// pin; emits one-cycle rise/fall strobes of the filtered level.
module i2c_pin_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          sync1_q, sync2_q, level_q, rise_q, fall_q;
  logic [CW-1:0] cnt_q;

  // Level only moves after FILT_LEN consecutive samples disagree with it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILT_LEN - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
        rise_q  <= sync2_q;
        fall_q  <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target: filtered SCL/SDA, START/STOP detection, address match, byte
// receive with wr_valid strobe and byte transmit driven by rd_req/rd_data.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDR     = DEF_ADDR,
  parameter int         FILT_LEN = DEF_FILT_LEN
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  logic [1:0] rst_sync_q;
  logic       rst_n_s;
  logic       scl_lvl_s, scl_rise_s, scl_fall_s;
  logic       sda_lvl_s, sda_rise_s, sda_fall_s;
  logic       start_s, stop_s;
  logic [7:0] rx_byte_s;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] sh_q, sh_d, tx_q, tx_d, wr_data_q, wr_data_d;
  logic       rw_q, rw_d, acked_q, acked_d, sda_oe_q, sda_oe_d;
  logic       wr_valid_q, wr_valid_d, rd_req_q, rd_req_d, busy_q, busy_d;

  // Assertion is immediate (SDA released at once); release waits two clocks
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_q[1];

  i2c_pin_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_i(sys_clk), .rst_ni(rst_n_s), .pin_i(scl_i),
    .level_o(scl_lvl_s), .rise_o(scl_rise_s), .fall_o(scl_fall_s)
  );

  i2c_pin_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_i(sys_clk), .rst_ni(rst_n_s), .pin_i(sda_i),
    .level_o(sda_lvl_s), .rise_o(sda_rise_s), .fall_o(sda_fall_s)
  );

  assign start_s   = sda_fall_s & scl_lvl_s;
  assign stop_s    = sda_rise_s & scl_lvl_s;
  assign rx_byte_s = {sh_q[6:0], sda_lvl_s};

  // State and output registers
  always_ff @(posedge sys_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      sh_q       <= 8'h00;
      tx_q       <= 8'h00;
      rw_q       <= 1'b0;
      acked_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_data_q  <= 8'h00;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      acked_q    <= acked_d;
      sda_oe_q   <= sda_oe_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic; bus conditions pre-empt any SCL edge in the same cycle
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    rw_d       = rw_q;
    acked_d    = acked_q;
    sda_oe_d   = sda_oe_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    busy_d     = busy_q;
    if (start_s) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sh_d      = 8'h00;
      sda_oe_d  = 1'b0;
    end else if (stop_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_WR_BYTE: begin
          if (scl_rise_s) begin
            sh_d      = rx_byte_s;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q != 3'd7) begin
              state_d = state_q;
            end else if (state_q == ST_WR_BYTE) begin
              state_d = ST_WR_ACK;
            end else if (addr_hit(rx_byte_s, ADDR)) begin
              state_d = ST_ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = rx_byte_s[RW_BIT];
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            state_d = state_q;
          end
        end
        // sda_oe_q doubles as the phase flag: low before the ACK bit, high during it
        ST_ADDR_ACK, ST_WR_ACK: begin
          if (scl_fall_s && !sda_oe_q) begin
            sda_oe_d = 1'b1;
            if (state_q == ST_WR_ACK) begin
              wr_valid_d = 1'b1;
              wr_data_d  = sh_q;
            end else begin
              wr_valid_d = 1'b0;
            end
          end else if (scl_fall_s) begin
            bit_cnt_d = 3'd0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              tx_d     = rd_data;
              sda_oe_d = ~rd_data[7];
              state_d  = ST_RD_BYTE;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_WR_BYTE;
            end
          end else if (scl_rise_s) begin
            rd_req_d = (state_q == ST_ADDR_ACK) && rw_q && sda_oe_q;
          end else begin
            rd_req_d = 1'b0;
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall_s && bit_cnt_q == 3'd7) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 3'd0;
            acked_d   = 1'b0;
            state_d   = ST_RD_ACK;
          end else if (scl_fall_s) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = {tx_q[6:0], 1'b0};
            sda_oe_d  = ~tx_q[6];
          end else begin
            tx_d = tx_q;
          end
        end
        ST_RD_ACK: begin
          if (scl_rise_s && !sda_lvl_s) begin
            rd_req_d = 1'b1;
            acked_d  = 1'b1;
          end else if (scl_rise_s) begin
            state_d  = ST_WAIT;
            sda_oe_d = 1'b0;
          end else if (scl_fall_s && acked_q) begin
            tx_d      = rd_data;
            sda_oe_d  = ~rd_data[7];
            bit_cnt_d = 3'd0;
            state_d   = ST_RD_BYTE;
          end else begin
            acked_d = acked_q;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: the bench plays the I2C initiator on a
// wired-AND bus and checks strobes, ACKs and read data against its own model.
module tb_i2c_target;

  localparam int Q = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, wr_valid, rd_req, busy;
  logic [7:0] wr_data;
  logic [7:0] rd_data = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_seen  = 0;
  int rd_seen  = 0;
  int rd_exp   = 0;
  int wr_base, rd_base;
  logic [7:0] exp_wr[$];
  logic [7:0] rd_src[$];
  bit   model_sel = 1'b0;
  bit   model_rw  = 1'b0;
  logic ack, s;
  logic [7:0] d;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target #(.ADDR(7'h50), .FILT_LEN(3)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .wr_data(wr_data), .wr_valid(wr_valid), .rd_req(rd_req),
    .rd_data(rd_data), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Strobe monitor: every wr_valid must match a byte the model expects;
  // every rd_req is counted and hands the DUT the next byte to send.
  always @(negedge sys_clk) begin
    if (wr_valid || rd_req) check("strobe_exclusive", {31'd0, wr_valid & rd_req}, 32'd0);
    if (wr_valid) begin
      wr_seen++;
      check("wr_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
      if (exp_wr.size() > 0) check("wr_data", {24'd0, wr_data}, {24'd0, exp_wr.pop_front()});
    end
    if (rd_req) begin
      rd_seen++;
      if (rd_src.size() > 0) rd_data = rd_src.pop_front();
      else rd_data = 8'hFF;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2*Q);
    sda_m = 1'b0; tick(2*Q);
    scl_m = 1'b0; tick(Q);
    model_sel = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(2*Q);
    sda_m = 1'b1; tick(2*Q);
    model_sel = 1'b0;
  endtask

  task automatic i2c_bit(input logic b, input bit glitch, output logic smp);
    sda_m = b; tick(Q/2);
    if (glitch) begin
      scl_m = 1'b1; tick(1); scl_m = 1'b0;
    end
    tick(Q/2);
    scl_m = 1'b1; tick(Q);
    smp = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic a);
    logic smp;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], (7 - i) == glitch_bit, smp);
    i2c_bit(1'b1, 1'b0, smp);
    a = ~smp;
  endtask

  task automatic send_addr(input logic [7:0] b);
    logic a;
    model_sel = (b[7:1] == 7'h50);
    model_rw  = b[0];
    if (model_sel && model_rw) rd_exp++;
    send_byte(b, -1, a);
    check("addr_ack", {31'd0, a}, {31'd0, model_sel});
  endtask

  task automatic write_byte(input logic [7:0] b, input int glitch_bit);
    logic a;
    if (model_sel && !model_rw) exp_wr.push_back(b);
    send_byte(b, glitch_bit, a);
    check("data_ack", {31'd0, a}, {31'd0, model_sel & ~model_rw});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic mack);
    logic [7:0] r;
    logic smp;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, 1'b0, smp);
      r[i] = smp;
    end
    i2c_bit(~mack, 1'b0, smp);
    if (mack) rd_exp++;
    check("rd_byte", {24'd0, r}, {24'd0, exp});
  endtask

  initial begin
    tick(6);
    sys_rst_n = 1'b1;
    tick(6);
    check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_rd_req", {31'd0, rd_req}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wr_data", {24'd0, wr_data}, 32'd0);

    // Write A0, 3C, STOP
    wr_base = wr_seen;
    i2c_start();
    send_addr(8'hA0);
    check("busy_after_match", {31'd0, busy}, 32'd1);
    write_byte(8'h3C, -1);
    i2c_stop();
    tick(Q);
    check("wr_count_3c", wr_seen - wr_base, 1);
    check("wr_data_3c", {24'd0, wr_data}, 32'h3C);
    check("busy_after_stop", {31'd0, busy}, 32'd0);

    // Read A1, rd_data A5, master NACK
    rd_base = rd_seen;
    rd_src.push_back(8'hA5);
    i2c_start();
    send_addr(8'hA1);
    read_byte(8'hA5, 1'b0);
    check("sda_released_nack", {31'd0, sda_oe}, 32'd0);
    i2c_stop();
    tick(Q);
    check("rd_count_a5", rd_seen - rd_base, 1);
    check("busy_after_read", {31'd0, busy}, 32'd0);

    // Address 0x51: no ACK, no strobes, never busy
    wr_base = wr_seen; rd_base = rd_seen;
    i2c_start();
    send_addr(8'hA2);
    check("busy_nomatch", {31'd0, busy}, 32'd0);
    write_byte(8'h55, -1);
    i2c_stop();
    tick(Q);
    check("nomatch_strobes", (wr_seen - wr_base) + (rd_seen - rd_base), 0);

    // Write 11, repeated START, read with ACK then NACK
    wr_base = wr_seen; rd_base = rd_seen;
    rd_src.push_back(8'h5A);
    rd_src.push_back(8'hC3);
    i2c_start();
    send_addr(8'hA0);
    write_byte(8'h11, -1);
    i2c_start();
    send_addr(8'hA1);
    check("busy_rstart", {31'd0, busy}, 32'd1);
    read_byte(8'h5A, 1'b1);
    read_byte(8'hC3, 1'b0);
    i2c_stop();
    tick(Q);
    check("rstart_wr_count", wr_seen - wr_base, 1);
    check("rstart_rd_count", rd_seen - rd_base, 2);
    check("rstart_wr_data", {24'd0, wr_data}, 32'h11);

    // One-cycle SCL glitch in the low phase of a data bit
    wr_base = wr_seen;
    i2c_start();
    send_addr(8'hA0);
    write_byte(8'h3C, 3);
    i2c_stop();
    tick(Q);
    check("glitch_wr_count", wr_seen - wr_base, 1);
    check("glitch_wr_data", {24'd0, wr_data}, 32'h3C);

    // Reset while the address ACK is being driven
    wr_base = wr_seen; rd_base = rd_seen;
    i2c_start();
    d = 8'hA0;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], 1'b0, s);
    sda_m = 1'b1;
    tick(Q);
    check("ack_driven", {31'd0, sda_oe}, 32'd1);
    #3 sys_rst_n = 1'b0;
    #1 check("rst_releases_sda", {31'd0, sda_oe}, 32'd0);
    check("rst_clears_busy", {31'd0, busy}, 32'd0);
    model_sel = 1'b0;
    tick(4);
    sys_rst_n = 1'b1;
    tick(4);
    i2c_bit(1'b1, 1'b0, s);
    check("no_ack_after_rst", {31'd0, s}, 32'd1);
    write_byte(8'h77, -1);
    i2c_stop();
    tick(Q);
    check("post_rst_strobes", (wr_seen - wr_base) + (rd_seen - rd_base), 0);
    i2c_start();
    send_addr(8'hA0);
    write_byte(8'h42, -1);
    i2c_stop();
    tick(Q);
    check("post_rst_wr_data", {24'd0, wr_data}, 32'h42);

    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_req_total", rd_seen, rd_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDR, 7'h50, 7-bit target address matched after START.
REQ-002 Parameter FILT_LEN, 3, number of consecutive equal samples that qualify a filtered SCL/SDA level.
REQ-003 sys_clk  in  1  system clock; sole clock, 51.2 MHz nominal.
REQ-004 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 scl_i  in  1  bus SCL input, asynchronous to sys_clk.
REQ-006 sda_i  in  1  bus SDA input, asynchronous to sys_clk.
REQ-007 sda_oe  out  1  1 = pull SDA low; pad is open-drain, and SDA is never driven high.
REQ-008 wr_data  out  8  last byte received from the initiator.
REQ-009 wr_valid  out  1  one-cycle strobe; wr_data is valid in the same cycle.
REQ-010 rd_req  out  1  one-cycle strobe requesting the next byte to send.
REQ-011 rd_data  in  8  byte to send, sampled as defined in REQ-021.
REQ-012 busy  out  1  high from an address-matched START until STOP.

Function
REQ-013 Synchronize SCL and SDA with 2 flops each, then filter: the filtered level changes only after FILT_LEN identical synchronized samples.
REQ-014 Edges are derived from the filtered signals only; SCL edge detection adds latency of 2 + FILT_LEN cycles.
REQ-015 START = filtered SDA falling while filtered SCL high; STOP = filtered SDA rising while filtered SCL high.
REQ-016 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT.
REQ-017 START from any state -> ADDR, clears the bit counter, and sets sda_oe=0 in the same cycle; this covers repeated START.
REQ-018 STOP from any state -> IDLE, sets sda_oe=0, and clears busy.
REQ-019 ADDR: shift SDA MSB-first on each SCL rising edge for 8 bits.
  - Address match: -> ADDR_ACK and set busy.
  - No match: -> WAIT and leave sda_oe at 0.
REQ-020 ACK timing: sda_oe=1 from the SCL falling edge after bit 8 until the next SCL falling edge after bit 9.
REQ-021 After the address ACK with R/W=0 -> WR_BYTE; with R/W=1 -> RD_BYTE.
  - For R/W=1, rd_req pulses on the SCL rising edge of the ACK bit.
  - rd_data is latched on the following SCL falling edge.
  - The MSB is presented on that same falling edge.
REQ-022 WR_BYTE: after 8 rising edges, wr_data is updated and wr_valid pulses on the next SCL falling edge, with ACK per REQ-020 (WR_ACK); then -> WR_BYTE.
REQ-023 RD_BYTE presentation:
  - sda_oe = ~current bit, updated on each SCL falling edge.
  - After bit 8, release SDA (sda_oe=0) on the next falling edge and enter RD_ACK.
REQ-024 RD_ACK: sample SDA on the SCL rising edge.
  - Sampled 0 (ACK): pulse rd_req in that cycle and continue per REQ-021.
  - Sampled 1 (NACK): -> WAIT with sda_oe=0.
REQ-025 WAIT: ignore SCL edges and leave only on START or STOP.
REQ-026 Simultaneous events: START/STOP take priority over any SCL edge in the same cycle.
REQ-027 wr_valid and rd_req are never asserted in the same cycle.
REQ-028 The bit counter is 3 bits and wraps 7->0 only at byte boundaries.

Reset
REQ-029 Reset values, set asynchronously on sys_rst_n=0:
  - sda_oe=0, wr_valid=0, rd_req=0, busy=0, wr_data=8'h00;
  - state=IDLE;
  - filters preset to 1 (bus idle high).
REQ-030 Reset release is synchronized internally; if reset is asserted mid-transfer, SDA is released immediately and the bus is treated as idle until the next START.

Structure
REQ-031 Shared package i2c_pkg holds the state enum, the R/W bit position, and the default ADDR/FILT_LEN constants.
REQ-032 One sub-module, i2c_pin_filter (sync + glitch filter + rise/fall strobes), is instantiated once for SCL and once for SDA.
REQ-033 Target size is about 250 lines of RTL total.

Verification
REQ-034 Write A0 (0x50,W), 0x3C, STOP -> ACK on both bytes; one wr_valid with wr_data=8'h3C; busy falls on STOP.
REQ-035 Read A1 (0x50,R) with rd_data=8'hA5, master NACK -> exactly one rd_req; SDA bits 1,0,1,0,0,1,0,1; then WAIT/IDLE.
REQ-036 Address 0x51 -> no ACK (SDA high on the 9th bit); no strobes; busy=0.
REQ-037 Write 0x11, repeated START, then read with master ACK then NACK -> wr_valid once; rd_req exactly twice.
REQ-038 1-cycle glitch on SCL during a data bit -> no extra bit is shifted; received byte is unchanged.
REQ-039 sys_rst_n low while ACK is driven -> sda_oe=0 within the same cycle; after release, no strobes until the next START.
